// File: rtl/led_ctrl_pkg.sv
// Shared types and helpers for the LED controller array: mode encoding,
// command width and broadcast address.
package led_ctrl_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_OFF    = 2'd0;
  localparam mode_t MODE_ON     = 2'd1;
  localparam mode_t MODE_BLINK1 = 2'd2;
  localparam mode_t MODE_BLINK2 = 2'd3;

  function automatic int cmd_width(input int addr_w);
    return addr_w + 2;
  endfunction

  // All-ones address of the given width selects every LED at once.
  function automatic logic [31:0] bcast_addr(input int addr_w);
    return (32'd1 << addr_w) - 32'd1;
  endfunction

endpackage

// File: rtl/led_pattern_gen.sv
// Free-running blink source: p1 toggles every P1_HALF cycles, and p2 toggles
// on each rising edge of p1.
module led_pattern_gen #(
  parameter int P1_HALF = 1000000,
  parameter int CNT_W   = 20
) (
  input  logic CLK,
  input  logic RESET,
  output logic p1,
  output logic p2
);

  logic [CNT_W-1:0] r_cnt;

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_cnt <= '0;
      p1    <= 1'b0;
      p2    <= 1'b0;
    end else if (r_cnt == CNT_W'(P1_HALF - 1)) begin
      r_cnt <= '0;
      p1    <= ~p1;
      if (!p1) p2 <= ~p2;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_controller_array.sv
// Serial-command LED controller: synchronised SCLK/DATA/LATCH, per-LED 2-bit
// modes with addressed or broadcast writes, and registered LED outputs.
module led_controller_array
  import led_ctrl_pkg::*;
#(
  parameter int NUM_LEDS = 20,
  parameter int ADDR_W   = 5,
  parameter int P1_HALF  = 1000000,
  parameter int CNT_W    = 20
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                SCLK,
  input  logic                DATA,
  input  logic                LATCH,
  output logic [NUM_LEDS-1:0] LED,
  output logic                CMD_OK,
  output logic                CMD_ERR
);

  localparam int CMD_W = cmd_width(ADDR_W);
  localparam int BC_W  = $clog2(CMD_W + 2);
  localparam logic [ADDR_W-1:0] BCAST = ADDR_W'(bcast_addr(ADDR_W));

  logic r_sclk_s1, r_sclk_s2, r_sclk_s3;
  logic r_data_s1, r_data_s2;
  logic r_latch_s1, r_latch_s2, r_latch_s3;

  logic [CMD_W-1:0]    r_shift;
  logic [BC_W-1:0]     r_cnt;
  mode_t               r_mode [NUM_LEDS];
  logic [NUM_LEDS-1:0] r_led;
  logic                r_ok, r_err;

  logic              w_sclk_rise, w_latch_rise;
  logic              w_wr_one, w_wr_all;
  logic              w_p1, w_p2;
  mode_t             w_mode_f;
  logic [ADDR_W-1:0] w_addr;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      {r_sclk_s1, r_sclk_s2, r_sclk_s3}    <= '0;
      {r_data_s1, r_data_s2}               <= '0;
      {r_latch_s1, r_latch_s2, r_latch_s3} <= '0;
    end else begin
      {r_sclk_s3, r_sclk_s2, r_sclk_s1}    <= {r_sclk_s2, r_sclk_s1, SCLK};
      {r_data_s2, r_data_s1}               <= {r_data_s1, DATA};
      {r_latch_s3, r_latch_s2, r_latch_s1} <= {r_latch_s2, r_latch_s1, LATCH};
    end
  end

  assign w_sclk_rise  = r_sclk_s2 & ~r_sclk_s3;
  assign w_latch_rise = r_latch_s2 & ~r_latch_s3;
  assign w_mode_f     = r_shift[CMD_W-1:ADDR_W];
  assign w_addr       = r_shift[ADDR_W-1:0];

  // Bit clocks are ignored while LATCH is high, so a latch sees the finished word.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (w_latch_rise) begin
      r_cnt <= '0;
    end else if (w_sclk_rise && !r_latch_s2) begin
      r_shift <= {r_shift[CMD_W-2:0], r_data_s2};
      if (r_cnt != BC_W'(CMD_W + 1)) r_cnt <= r_cnt + 1'b1;
    end
  end

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    w_wr_one = 1'b0;
    w_wr_all = 1'b0;
    if (w_latch_rise && (r_cnt == BC_W'(CMD_W))) begin
      if (w_addr == BCAST)                    w_wr_all = 1'b1;
      else if (w_addr < ADDR_W'(NUM_LEDS))    w_wr_one = 1'b1;
    end
  end

  // NOTE: the mode array is reset explicitly, since LEDs must come up dark.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < NUM_LEDS; i++) r_mode[i] <= MODE_OFF;
      r_ok  <= 1'b0;
      r_err <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (w_wr_all || (w_wr_one && (w_addr == ADDR_W'(i)))) r_mode[i] <= w_mode_f;
      end
      r_ok  <= w_wr_one | w_wr_all;
      r_err <= w_latch_rise & ~(w_wr_one | w_wr_all);
    end
  end

  led_pattern_gen #(
    .P1_HALF (P1_HALF),
    .CNT_W   (CNT_W)
  ) u_pattern (
    .CLK   (CLK),
    .RESET (RESET),
    .p1    (w_p1),
    .p2    (w_p2)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_led <= '0;
    end else begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        case (r_mode[i])
          MODE_OFF:    r_led[i] <= 1'b0;
          MODE_ON:     r_led[i] <= 1'b1;
          MODE_BLINK1: r_led[i] <= w_p1;
          default:     r_led[i] <= w_p2;
        endcase
      end
    end
  end

  assign LED     = r_led;
  assign CMD_OK  = r_ok;
  assign CMD_ERR = r_err;

endmodule

// File: tb/tb_led_controller_array.sv
// Directed bench for led_controller_array: expected status per command is queued
// at stimulus time and popped when CMD_OK/CMD_ERR fires; LEDs follow a time-based model.
module tb_led_controller_array;

  localparam int NUM_LEDS = 20;
  localparam int ADDR_W   = 5;
  localparam int P1_HALF  = 4;
  localparam int CNT_W    = 3;

  logic CLK = 1'b0, RESET = 1'b0, SCLK = 1'b0, DATA = 1'b0, LATCH = 1'b0;
  logic [NUM_LEDS-1:0] LED;
  logic CMD_OK, CMD_ERR;

  typedef struct {
    bit         ok;
    logic [1:0] mode;
    logic [4:0] addr;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  logic [1:0] m_mode [NUM_LEDS];
  int  t;
  bit  prev_pulse;
  int  n_cmp = 0;
  int  n_err = 0;

  always #5 CLK = ~CLK;

  led_controller_array #(
    .NUM_LEDS (NUM_LEDS),
    .ADDR_W   (ADDR_W),
    .P1_HALF  (P1_HALF),
    .CNT_W    (CNT_W)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .SCLK    (SCLK),
    .DATA    (DATA),
    .LATCH   (LATCH),
    .LED     (LED),
    .CMD_OK  (CMD_OK),
    .CMD_ERR (CMD_ERR)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Rising CLK edges since reset release.
  always @(posedge CLK or negedge RESET) begin
    if (!RESET) t <= 0;
    else        t <= t + 1;
  end

  // LED after edge t shows the pattern as it stood after edge t-1.
  function automatic logic [NUM_LEDS-1:0] exp_led();
    logic p1d, p2d;
    logic [NUM_LEDS-1:0] v;
    p1d = (t == 0) ? 1'b0 : ((((t - 1) / P1_HALF) % 2) == 1);
    p2d = (t == 0) ? 1'b0 : (((((t - 1) + P1_HALF) / (2 * P1_HALF)) % 2) == 1);
    for (int i = 0; i < NUM_LEDS; i++) begin
      case (m_mode[i])
        2'd0:    v[i] = 1'b0;
        2'd1:    v[i] = 1'b1;
        2'd2:    v[i] = p1d;
        default: v[i] = p2d;
      endcase
    end
    return v;
  endfunction

  always @(negedge CLK) begin
    if (RESET) begin
      if (prev_pulse) check("pulse_width", {30'd0, CMD_OK, CMD_ERR}, 32'd0);
      if (CMD_OK || CMD_ERR) begin
        check("ok_err_exclusive", {31'd0, CMD_OK & CMD_ERR}, 32'd0);
        if (q.size() == 0) begin
          check("unexpected_status", {30'd0, CMD_OK, CMD_ERR}, 32'd0);
        end else begin
          mon_e = q.pop_front();
          check("cmd_ok", {31'd0, CMD_OK}, {31'd0, mon_e.ok});
          check("cmd_err", {31'd0, CMD_ERR}, {31'd0, !mon_e.ok});
          if (mon_e.ok) begin
            if (mon_e.addr == 5'h1F) for (int i = 0; i < NUM_LEDS; i++) m_mode[i] = mon_e.mode;
            else m_mode[mon_e.addr] = mon_e.mode;
          end
        end
      end
      prev_pulse = CMD_OK || CMD_ERR;
    end else begin
      prev_pulse = 1'b0;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic shift_bits(input logic [7:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      DATA = w[i];
      cyc(4);
      SCLK = 1'b1;
      cyc(4);
      SCLK = 1'b0;
    end
  endtask

  task automatic push_exp(input logic [7:0] w, input bit ok);
    exp_t e;
    e.ok   = ok;
    e.mode = w[6:5];
    e.addr = w[4:0];
    q.push_back(e);
  endtask

  task automatic expect_drained(input string tag);
    check(tag, q.size(), 32'd0);
    q.delete();
  endtask

  task automatic send(input string tag, input logic [7:0] w, input int n, input bit ok);
    shift_bits(w, n);
    push_exp(w, ok);
    LATCH = 1'b1;
    cyc(4);
    LATCH = 1'b0;
    cyc(4);
    expect_drained(tag);
  endtask

  task automatic led_window(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1);
      check(tag, {12'd0, LED}, {12'd0, exp_led()});
    end
  endtask

  initial begin
    for (int i = 0; i < NUM_LEDS; i++) m_mode[i] = 2'd0;
    cyc(3);
    check("reset_led", {12'd0, LED}, 32'd0);
    check("reset_ok", {31'd0, CMD_OK}, 32'd0);
    check("reset_err", {31'd0, CMD_ERR}, 32'd0);
    RESET = 1'b1;
    cyc(2);

    // ON to LED 3
    send("t1_status", 8'b0_01_00011, 7, 1'b1);
    check("t1_led_const", {12'd0, LED}, 32'h00008);
    led_window("t1_led", 2);

    // Short and long words are rejected
    send("t3_short", 8'b00_101010, 6, 1'b0);
    led_window("t3_short_led", 2);
    send("t3_long", 8'b1010_0101, 8, 1'b0);
    led_window("t3_long_led", 2);

    // Address range edge
    send("t4_addr20", 8'b0_01_10100, 7, 1'b0);
    led_window("t4_addr20_led", 2);
    send("t4_addr19", 8'b0_01_10011, 7, 1'b1);
    check("t4_led19", {31'd0, LED[19]}, 32'd1);
    check("t4_led_const", {12'd0, LED}, 32'h80008);

    // Broadcast BLINK1, then LED 0 to BLINK2
    send("t2_bcast", 8'b0_10_11111, 7, 1'b1);
    led_window("t2_blink1", 24);
    send("t2_led0", 8'b0_11_00000, 7, 1'b1);
    led_window("t2_blink2", 40);

    // SCLK rise together with LATCH rise is ignored
    shift_bits(8'b0_01_00101, 7);
    DATA = 1'b1;
    cyc(4);
    push_exp(8'b0_01_00101, 1'b1);
    SCLK  = 1'b1;
    LATCH = 1'b1;
    cyc(4);
    SCLK  = 1'b0;
    LATCH = 1'b0;
    cyc(4);
    expect_drained("t5_status");
    led_window("t5_led", 2);
    send("t5_next", 8'b0_00_00101, 7, 1'b1);
    led_window("t5_next_led", 2);

    // Reset mid-command
    shift_bits(8'b0_11_10110, 4);
    RESET = 1'b0;
    cyc(2);
    check("t6_rst_led", {12'd0, LED}, 32'd0);
    check("t6_rst_ok", {30'd0, CMD_OK, CMD_ERR}, 32'd0);
    for (int i = 0; i < NUM_LEDS; i++) m_mode[i] = 2'd0;
    q.delete();
    RESET = 1'b1;
    cyc(2);
    send("t6_status", 8'b0_01_00001, 7, 1'b1);
    check("t6_led_const", {12'd0, LED}, 32'h00002);
    send("t6_blink", 8'b0_10_00000, 7, 1'b1);
    led_window("t6_divider", 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
